// File: rtl/fifo_flags_if.sv
// Bus bundle between a producer/consumer pair and fifo_flags.
// The master side drives push/pop requests; the slave (the FIFO) returns data and status.
interface fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int PT_WIDTH = $clog2(DEPTH);

  logic               write_enb;
  logic [WIDTH-1:0]   data_in;
  logic               read_enb;
  logic               err_clr;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [PT_WIDTH:0]  count;
  logic               overflow;
  logic               underflow;

  modport master (
    output write_enb, data_in, read_enb, err_clr,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_enb, data_in, read_enb, err_clr,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_flags #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int PT_WIDTH      = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input logic        clock,
  input logic        reset,
  fifo_flags_if.slave bus
);
  localparam logic [PT_WIDTH:0] ONE    = 1;
  localparam logic [PT_WIDTH:0] AF_LVL = (PT_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PT_WIDTH:0] AE_LVL = (PT_WIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PT_WIDTH:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_data_valid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;

  logic              w_rd_acc, w_wr_acc, w_empty_nxt, w_full_nxt;
  logic [PT_WIDTH:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic [WIDTH-1:0]  w_head_nxt;

  // Handshake: a pop is taken when read_enb=1 and the FIFO is not empty; a push is
  // taken when write_enb=1 and there is room, where a same-cycle pop also makes room.
  // Requests that are not taken are simply dropped and recorded in the sticky flags.
  always_comb begin
    w_rd_acc     = bus.read_enb && !r_empty;
    w_wr_acc     = bus.write_enb && (!r_full || w_rd_acc);
    w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + ONE : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + ONE : r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + ONE;
    else if (!w_wr_acc && w_rd_acc)
      w_count_nxt = r_count - ONE;
    w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_full_nxt   = (w_wr_ptr_nxt[PT_WIDTH-1:0] == w_rd_ptr_nxt[PT_WIDTH-1:0]) &&
                   (w_wr_ptr_nxt[PT_WIDTH] != w_rd_ptr_nxt[PT_WIDTH]);
    // The next head may be the word being written this very cycle, so bypass memory.
    w_head_nxt   = (w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt)) ? bus.data_in
                                                            : r_mem[w_rd_ptr_nxt[PT_WIDTH-1:0]];
  end

  always_ff @(posedge clock) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr[PT_WIDTH-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_aempty     <= 1'b1;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      r_afull  <= (w_count_nxt >= AF_LVL);
      r_aempty <= (w_count_nxt <= AE_LVL);
      r_ovf    <= (r_ovf && !bus.err_clr) || (bus.write_enb && !w_wr_acc);
      r_udf    <= (r_udf && !bus.err_clr) || (bus.read_enb && r_empty);
      if (FWFT != 0) begin
        if (!w_empty_nxt)
          r_data_out <= w_head_nxt;
        r_data_valid <= !w_empty_nxt;
      end else begin
        if (w_rd_acc)
          r_data_out <= r_mem[r_rd_ptr[PT_WIDTH-1:0]];
        r_data_valid <= w_rd_acc;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = r_data_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's basic single-clock FIFO and adds the following:
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; power of two, >=4
PT_WIDTH, $clog2(DEPTH), pointer index width (derived; do not override)
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
write_enb  input  1  push request
data_in  input  WIDTH  push data
read_enb  input  1  pop request
data_out  output  WIDTH  read data
data_valid  output  1  data_out holds newly popped word (standard mode); equals ~empty in FWFT mode
full  output  1  count == DEPTH
empty  output  1  no word available to read
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  PT_WIDTH+1  words held, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count go to 0. data_out = 0. data_valid = 0. full = 0. almost_full = 0. overflow = 0. underflow = 0.
  - empty = 1 and almost_empty = 1.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words immediately. The first push after release behaves as a push into an empty FIFO.
- Pointers are PT_WIDTH+1 bits. The low PT_WIDTH bits address memory. The MSB is the wrap bit.
  - full: equal index bits and differing MSB.
  - empty: pointers equal.
- All status outputs are registered. They reflect the state after the clock edge.
- Write acceptance:
  - A write is accepted when write_enb=1 and either (!full) or (full and a read is accepted the same cycle).
  - A write while full with no accepted read is dropped and sets overflow.
- Read acceptance:
  - A read is accepted when read_enb=1 and !empty.
  - read_enb while empty sets underflow. This holds even if a write occurs the same cycle: the new word is not readable until the next cycle.
- Simultaneous accepted read and write: count is unchanged, both pointers advance, and full/empty hold.
- count: +1 on an accepted write only, -1 on an accepted read only.
  - Never wraps past DEPTH or below 0.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
- Standard mode (FWFT=0):
  - data_out updates one cycle after an accepted read, and data_valid pulses high for exactly that cycle.
  - Otherwise data_out holds its last value. It never goes to Z or X.
- FWFT mode (FWFT=1):
  - The head word is presented on data_out while empty=0. read_enb acknowledges and pops it.
  - A write into an empty FIFO makes empty fall and data appear on data_out on the next edge (1-cycle write-to-visible latency).
  - After a pop, the next word appears on the following edge with no bubble.
  - count includes the word on data_out.
- Error flags: err_clr clears overflow and underflow on the next edge. If an error event occurs in the same cycle as err_clr, the flag stays set.
- Threshold boundaries: almost_full and almost_empty may be asserted simultaneously for small DEPTH. Both follow count with no hysteresis.

Test Plan:
1. Reset, then push 16 words 0x01..0x10 (DEPTH=16) -> count goes to 16, full=1, almost_full=1 from count=14. A 17th write sets overflow=1 and count stays 16.
2. Drain the full FIFO in standard mode -> data_out = 0x01..0x10 in order, each one cycle after read_enb, with data_valid pulsing. Then empty=1; a further read sets underflow=1 and data_out holds 0x10.
3. Full FIFO, assert write_enb and read_enb together for 8 cycles -> all 8 writes accepted, count stays 16, full stays 1, order preserved through pointer wrap.
4. FWFT=1, write 0xA5 into empty -> next edge empty=0 and data_out=0xA5 with no read. Pulse read_enb -> empty=1, count=0.
5. Write to empty with read_enb high in the same cycle -> underflow=1, count=1. Assert err_clr -> both flags 0 next edge.
6. Assert reset asynchronously mid-burst at count=9 -> count=0, empty=1, full=0 immediately without a clock edge. The next push/pop pair returns the new data.
